// File: rtl/btb_pkg.sv
// Shared types, counter encodings and helpers for the associative branch target buffer.
package btb_pkg;

  // 2-bit saturating direction counter encodings
  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;

  // Per-way entry contents; the tag is kept beside it because its width depends on SETS
  typedef struct packed {
    logic        valid;
    logic [1:0]  cnt;
    logic [31:0] target;
  } btb_entry_t;

  // Saturating counter step toward the resolved outcome
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    end else begin
      nxt = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup and resolve-side update bundle of the BTB.
interface btb_assoc_if;
  logic [31:0] lookup_pc;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        btb_pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        flush;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
    input  btb_hit, btb_target, btb_pred_taken
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
    output btb_hit, btb_target, btb_pred_taken
  );
endinterface

// File: rtl/btb_plru.sv
// Per-set tree pseudo-LRU state; one touch per cycle, victim read for the same set.
module btb_plru #(
  parameter int SETS  = 256,
  parameter int WAYS  = 2,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic [IDX_W-1:0] i_set,
  input  logic [WAY_W-1:0] i_way,
  input  logic             i_touch,
  output logic [WAY_W-1:0] o_victim
);

  localparam int PL_W = (WAYS > 1) ? WAYS - 1 : 1;

  logic [PL_W-1:0] r_plru [SETS];
  logic [PL_W-1:0] w_cur;
  logic [PL_W-1:0] w_next;

  assign w_cur = r_plru[i_set];

  // Tree bits point toward the victim: bit0 is the root, bits 1/2 pick inside each half
  generate
    if (WAYS == 4) begin : g_four
      // Victim walk and touch update for a 3-bit tree
      always_comb begin
        o_victim = w_cur[0] ? {1'b1, w_cur[2]} : {1'b0, w_cur[1]};
        w_next   = w_cur;
        if (i_way[1]) begin
          w_next[0] = 1'b0;
          w_next[2] = ~i_way[0];
        end else begin
          w_next[0] = 1'b1;
          w_next[1] = ~i_way[0];
        end
      end
    end else if (WAYS == 2) begin : g_two
      // Single bit names the victim; touching points it at the other way
      always_comb begin
        o_victim  = w_cur[0];
        w_next[0] = ~i_way[0];
      end
    end else begin : g_one
      // Direct-mapped: the only way is always the victim
      always_comb begin
        o_victim = 1'b0;
        w_next   = 1'b0;
      end
    end
  endgenerate

  // Tree state: cleared by reset or flush, advanced on update hit or allocation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
    end else if (i_flush) begin
      for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
    end else if (i_touch) begin
      r_plru[i_set] <= w_next;
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: zero-latency lookup, resolve-time update
// with 2-bit direction counters and tree-PLRU replacement.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int SETS = 256,
  parameter int WAYS = 2
) (
  input logic         clk,
  input logic         rst,
  btb_assoc_if.slave  bus
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic             r_valid [WAYS][SETS];
  logic [1:0]       r_cnt   [WAYS][SETS];
  logic [TAG_W-1:0] r_tag   [WAYS][SETS];
  logic [31:0]      r_tgt   [WAYS][SETS];

  logic [IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0] w_lk_tag, w_up_tag;
  btb_entry_t       w_lk_ent [WAYS];
  logic             w_hit, w_pred;
  logic [31:0]      w_tgt;
  logic             w_up_hit, w_free;
  logic [WAY_W-1:0] w_up_hit_way, w_free_way, w_victim, w_wr_way;
  logic             w_do_hit, w_do_alloc;
  logic             w_unused;

  assign w_lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign w_lk_tag = bus.lookup_pc[31:IDX_W+2];
  assign w_up_idx = bus.upd_pc[IDX_W+1:2];
  assign w_up_tag = bus.upd_pc[31:IDX_W+2];
  assign w_unused = &{1'b0, bus.lookup_pc[1:0], bus.upd_pc[1:0]};

  // Lookup: at most one way matches, so OR-merging the matching way is exact
  always_comb begin
    w_hit  = 1'b0;
    w_tgt  = 32'd0;
    w_pred = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      w_lk_ent[w].valid  = r_valid[w][w_lk_idx] && (r_tag[w][w_lk_idx] == w_lk_tag);
      w_lk_ent[w].cnt    = r_cnt[w][w_lk_idx];
      w_lk_ent[w].target = r_tgt[w][w_lk_idx];
      w_hit  = w_hit | w_lk_ent[w].valid;
      w_tgt  = w_tgt | ({32{w_lk_ent[w].valid}} & w_lk_ent[w].target);
      w_pred = w_pred | (w_lk_ent[w].valid & (w_lk_ent[w].cnt >= CNT_WT));
    end
  end

  assign bus.btb_hit        = w_hit;
  assign bus.btb_target     = w_tgt;
  assign bus.btb_pred_taken = w_pred;

  // Update side: find hitting way and the lowest-numbered free way of the update set
  always_comb begin
    w_up_hit     = 1'b0;
    w_up_hit_way = '0;
    w_free       = 1'b0;
    w_free_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w][w_up_idx] && (r_tag[w][w_up_idx] == w_up_tag)) begin
        w_up_hit     = 1'b1;
        w_up_hit_way = WAY_W'(w);
      end else begin
        w_up_hit = w_up_hit;
      end
      if (!r_valid[w][w_up_idx]) begin
        w_free     = 1'b1;
        w_free_way = WAY_W'(w);
      end else begin
        w_free = w_free;
      end
    end
  end

  // Flush drops any coincident update; a not-taken miss changes nothing
  assign w_do_hit   = bus.upd_valid & ~bus.flush & w_up_hit;
  assign w_do_alloc = bus.upd_valid & ~bus.flush & ~w_up_hit & bus.upd_taken;
  assign w_wr_way   = w_up_hit ? w_up_hit_way : (w_free ? w_free_way : w_victim);

  btb_plru #(.SETS(SETS), .WAYS(WAYS), .IDX_W(IDX_W), .WAY_W(WAY_W)) u_plru (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (bus.flush),
    .i_set    (w_up_idx),
    .i_way    (w_wr_way),
    .i_touch  (w_do_hit | w_do_alloc),
    .o_victim (w_victim)
  );

  // Valid bits and counters: reset/flush clear validity, hits train, allocation seeds weak-taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          r_valid[w][s] <= 1'b0;
          r_cnt[w][s]   <= CNT_SNT;
        end
      end
    end else if (bus.flush) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) r_valid[w][s] <= 1'b0;
      end
    end else if (w_do_hit) begin
      r_cnt[w_wr_way][w_up_idx] <= cnt_next(r_cnt[w_wr_way][w_up_idx], bus.upd_taken);
    end else if (w_do_alloc) begin
      r_valid[w_wr_way][w_up_idx] <= 1'b1;
      r_cnt[w_wr_way][w_up_idx]   <= CNT_WT;
    end
  end

  // Tag and target payload: unreset storage, always qualified by the valid bit
  always_ff @(posedge clk) begin
    if (rst && w_do_hit && bus.upd_taken) begin
      r_tgt[w_wr_way][w_up_idx] <= bus.upd_target;
    end else if (rst && w_do_alloc) begin
      r_tag[w_wr_way][w_up_idx] <= w_up_tag;
      r_tgt[w_wr_way][w_up_idx] <= bus.upd_target;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed scoreboard bench for btb_assoc (SETS=256, WAYS=2).
module tb_btb_assoc;

  logic clk;
  logic rst;
  logic lk_req;
  int   n_cmp;
  int   n_bad;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] tgt;
    logic        pt;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;

  btb_assoc_if bus ();

  btb_assoc #(.SETS(256), .WAYS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a lookup for one cycle and queue its expected response
  task automatic look(input logic [31:0] pc, input string nm,
                      input logic h, input logic [31:0] t, input logic p);
    exp_t e;
    e.name = nm; e.hit = h; e.tgt = t; e.pt = p;
    bus.lookup_pc = pc;
    lk_req = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    lk_req = 1'b0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [31:0] t, input logic tk);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_target = t;
    bus.upd_taken  = tk;
  endtask

  // One update cycle with no checked lookup
  task automatic upd(input logic [31:0] pc, input logic [31:0] t, input logic tk);
    set_upd(pc, t, tk);
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
  endtask

  // Monitor: compare DUT lookup outputs against the queued expectation
  always @(negedge clk) begin
    if (lk_req) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow: lookup seen with no expectation queued");
      end else begin
        m_e = sb_q.pop_front();
        if (bus.btb_hit !== m_e.hit || bus.btb_target !== m_e.tgt || bus.btb_pred_taken !== m_e.pt) begin
          n_bad++;
          $display("FAIL %s: got hit=%0b tgt=%h pt=%0b, want hit=%0b tgt=%h pt=%0b",
                   m_e.name, bus.btb_hit, bus.btb_target, bus.btb_pred_taken,
                   m_e.hit, m_e.tgt, m_e.pt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    lk_req = 1'b0;
    rst = 1'b0;
    bus.lookup_pc = 32'h0;
    bus.upd_valid = 1'b0;
    bus.upd_pc = 32'h0;
    bus.upd_target = 32'h0;
    bus.upd_taken = 1'b0;
    bus.flush = 1'b0;
    @(posedge clk);
    #1;
    look(32'h0000_1000, "in_reset", 1'b0, 32'h0, 1'b0);
    rst = 1'b1;

    look(32'h0000_1000, "empty_miss", 1'b0, 32'h0, 1'b0);
    // Same-cycle allocate: lookup sees pre-update contents
    set_upd(32'h0000_1000, 32'h0000_2000, 1'b1);
    look(32'h0000_1000, "no_bypass_alloc", 1'b0, 32'h0, 1'b0);
    bus.upd_valid = 1'b0;
    look(32'h0000_1000, "alloc_hit", 1'b1, 32'h0000_2000, 1'b1);
    look(32'h0000_1003, "low_bits_ignored", 1'b1, 32'h0000_2000, 1'b1);
    look(32'h0000_1004, "other_set_miss", 1'b0, 32'h0, 1'b0);
    look(32'h0000_1400, "alias_miss", 1'b0, 32'h0, 1'b0);

    upd(32'h0000_1400, 32'h0000_3000, 1'b1);
    look(32'h0000_1000, "alias_keep_a", 1'b1, 32'h0000_2000, 1'b1);
    look(32'h0000_1400, "alias_hit_b", 1'b1, 32'h0000_3000, 1'b1);

    upd(32'h0000_5000, 32'h0000_6000, 1'b0);
    look(32'h0000_5000, "nt_miss_no_alloc", 1'b0, 32'h0, 1'b0);

    // Touch 0x1000 so way holding 0x1400 becomes the victim
    upd(32'h0000_1000, 32'h0000_2100, 1'b1);
    look(32'h0000_1000, "taken_retarget", 1'b1, 32'h0000_2100, 1'b1);
    upd(32'h0000_1800, 32'h0000_3800, 1'b1);
    look(32'h0000_1400, "plru_evicted", 1'b0, 32'h0, 1'b0);
    look(32'h0000_1800, "plru_new", 1'b1, 32'h0000_3800, 1'b1);
    look(32'h0000_1000, "plru_kept", 1'b1, 32'h0000_2100, 1'b1);

    // Counter training on 0x1000 (starts at 3)
    upd(32'h0000_1000, 32'hDEAD_0000, 1'b0);
    look(32'h0000_1000, "nt1_cnt2", 1'b1, 32'h0000_2100, 1'b1);
    upd(32'h0000_1000, 32'hDEAD_0000, 1'b0);
    look(32'h0000_1000, "nt2_cnt1", 1'b1, 32'h0000_2100, 1'b0);
    for (int i = 0; i < 4; i++) upd(32'h0000_1000, 32'h0000_2200, 1'b1);
    upd(32'h0000_1000, 32'hDEAD_0000, 1'b0);
    look(32'h0000_1000, "sat_hi_then_nt", 1'b1, 32'h0000_2200, 1'b1);
    upd(32'h0000_1000, 32'hDEAD_0000, 1'b0);
    look(32'h0000_1000, "cnt1_again", 1'b1, 32'h0000_2200, 1'b0);
    upd(32'h0000_1000, 32'hDEAD_0000, 1'b0);
    upd(32'h0000_1000, 32'hDEAD_0000, 1'b0);
    look(32'h0000_1000, "sat_lo_valid", 1'b1, 32'h0000_2200, 1'b0);
    upd(32'h0000_1000, 32'h0000_2300, 1'b1);
    look(32'h0000_1000, "from0_to1", 1'b1, 32'h0000_2300, 1'b0);
    upd(32'h0000_1000, 32'h0000_2300, 1'b1);
    look(32'h0000_1000, "from1_to2", 1'b1, 32'h0000_2300, 1'b1);

    // Same-cycle hit update: old target returned, new visible next cycle
    set_upd(32'h0000_1800, 32'h0000_3900, 1'b1);
    look(32'h0000_1800, "no_bypass_hit", 1'b1, 32'h0000_3800, 1'b1);
    bus.upd_valid = 1'b0;
    look(32'h0000_1800, "hit_retarget", 1'b1, 32'h0000_3900, 1'b1);

    // Flush wins over coincident taken update
    set_upd(32'h0000_4000, 32'h0000_5000, 1'b1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.upd_valid = 1'b0;
    look(32'h0000_4000, "flush_drop_upd", 1'b0, 32'h0, 1'b0);
    look(32'h0000_1000, "flush_a", 1'b0, 32'h0, 1'b0);
    look(32'h0000_1800, "flush_b", 1'b0, 32'h0, 1'b0);

    upd(32'h0000_1000, 32'h0000_2000, 1'b1);
    look(32'h0000_1000, "post_flush_alloc", 1'b1, 32'h0000_2000, 1'b1);

    // Reset asserted during an update cycle: update lost, table empty
    set_upd(32'h0000_1400, 32'h0000_3000, 1'b1);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    look(32'h0000_1000, "rst_hold_out0", 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    look(32'h0000_1000, "rst_cleared", 1'b0, 32'h0, 1'b0);
    look(32'h0000_1400, "rst_upd_dropped", 1'b0, 32'h0, 1'b0);

    @(posedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
